// File: rtl/i2s_apb_streamer_pkg.sv
// Shared definitions for the I2S APB streamer: FSM states, status bit map,
// default transceiver register addresses.
package i2s_apb_streamer_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CFG_S,
    CFG_A,
    POLL_S,
    POLL_A,
    TX_S,
    TX_A,
    RX_S,
    RX_A
  } streamer_state_t;

  typedef enum logic {
    RR_RX = 1'b0,
    RR_TX = 1'b1
  } rr_sel_t;

  localparam int ST_TX_FULL  = 3;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_RX_EMPTY = 0;

  localparam logic [31:0] DEF_CTRL_ADDR = 32'h0000_0000;
  localparam logic [31:0] DEF_TX_ADDR   = 32'h0000_0004;
  localparam logic [31:0] DEF_RX_ADDR   = 32'h0000_0008;
  localparam logic [31:0] DEF_STAT_ADDR = 32'h0000_000C;

endpackage

// File: rtl/i2s_apb_streamer_apb.sv
// APB setup/access sequencer: a start pulse latches address/direction/data,
// the following cycle is setup (penable=0) and the one after is access.
module apb_master_phase (
  input  logic        pclk,
  input  logic        preset,
  input  logic        start,
  input  logic        start_write,
  input  logic [31:0] start_addr,
  input  logic [31:0] start_data,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata
);

  logic setup;

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      setup   <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
    end else begin
      setup   <= start;
      penable <= setup;
      // Bus fields only change on a new start, so they hold through access.
      if (start) begin
        pwrite <= start_write;
        paddr  <= start_addr;
        pwdata <= start_data;
      end
    end
  end

endmodule

// File: rtl/i2s_apb_streamer.sv
// Flag-gated APB master bridging tx/rx sample streams to the I2S transceiver
// registers, with one-shot control-word loading and Tx/Rx round-robin.
module i2s_apb_streamer
  import i2s_apb_streamer_pkg::*;
#(
  parameter logic [31:0] CTRL_ADDR = DEF_CTRL_ADDR,
  parameter logic [31:0] TX_ADDR   = DEF_TX_ADDR,
  parameter logic [31:0] RX_ADDR   = DEF_RX_ADDR,
  parameter logic [31:0] STAT_ADDR = DEF_STAT_ADDR,
  parameter int          CNT_W     = 16
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             en,
  input  logic             cfg_load,
  input  logic [31:0]      cfg_word,
  input  logic [31:0]      tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [31:0]      rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             penable,
  output logic             pwrite,
  output logic [31:0]      paddr,
  output logic [31:0]      pwdata,
  input  logic [31:0]      prdata,
  output logic             busy,
  output logic [CNT_W-1:0] tx_count,
  output logic [CNT_W-1:0] rx_count
);

  streamer_state_t state, state_next;
  rr_sel_t         rr_last;
  logic            cfg_pending;
  logic [31:0]     cfg_hold;
  logic            tx_ok, rx_ok, tx_sel, rx_sel;
  logic            start, start_write;
  logic [31:0]     start_addr, start_data;

  always_comb begin
    tx_ok       = tx_valid & ~prdata[ST_TX_FULL];
    rx_ok       = ~prdata[ST_RX_EMPTY] & ~rx_valid;
    // When both sides are eligible, serve the one not served last time.
    tx_sel      = tx_ok & (~rx_ok | (rr_last == RR_RX));
    rx_sel      = rx_ok & ~tx_sel;
    state_next  = state;
    start       = 1'b0;
    start_write = 1'b0;
    start_addr  = STAT_ADDR;
    start_data  = '0;
    tx_ready    = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_pending) begin
          state_next  = CFG_S;
          start       = 1'b1;
          start_write = 1'b1;
          start_addr  = CTRL_ADDR;
          start_data  = cfg_hold;
        end else if (en) begin
          state_next = POLL_S;
          start      = 1'b1;
          start_addr = STAT_ADDR;
        end
      end
      CFG_S:  state_next = CFG_A;
      CFG_A:  state_next = IDLE;
      POLL_S: state_next = POLL_A;
      POLL_A: begin
        if (tx_sel) begin
          state_next  = TX_S;
          tx_ready    = 1'b1;
          start       = 1'b1;
          start_write = 1'b1;
          start_addr  = TX_ADDR;
          start_data  = tx_data;
        end else if (rx_sel) begin
          state_next = RX_S;
          start      = 1'b1;
          start_addr = RX_ADDR;
        end else begin
          state_next = IDLE;
        end
      end
      TX_S:    state_next = TX_A;
      TX_A:    state_next = IDLE;
      RX_S:    state_next = RX_A;
      RX_A:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state       <= IDLE;
      rr_last     <= RR_RX;
      cfg_pending <= 1'b0;
      cfg_hold    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_count    <= '0;
      rx_count    <= '0;
    end else begin
      state <= state_next;
      if (cfg_load) begin
        cfg_pending <= 1'b1;
        cfg_hold    <= cfg_word;
      end else if (state == CFG_A) begin
        cfg_pending <= 1'b0;
      end
      if (state == TX_A) begin
        tx_count <= tx_count + 1'b1;
        rr_last  <= RR_TX;
      end
      if (state == RX_A) begin
        rx_data  <= prdata;
        rx_valid <= 1'b1;
        rx_count <= rx_count + 1'b1;
        rr_last  <= RR_RX;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

  apb_master_phase u_apb (
    .pclk        (pclk),
    .preset      (preset),
    .start       (start),
    .start_write (start_write),
    .start_addr  (start_addr),
    .start_data  (start_data),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata)
  );

endmodule
